// File: rtl/gmii_rx_checker.sv
// ---------------------------------------------------------------------------
// gmii_rx_checker
// Receive-side GMII frame checker. Delimits frames on RX_DV, checks that the
// payload is an incrementing byte sequence seeded by the first byte, and
// reports per-frame status plus running frame/error counters.
//
// Ports
//   CLK          clock, all logic on rising edge
//   RESET        synchronous active-high reset
//   RX_DV        receive data valid
//   RX_ER        receive error (only honoured while RX_DV=1)
//   RXD[7:0]     receive data byte
//   BUSY         frame being received or dropped
//   FRAME_DONE   one-cycle pulse at frame end
//   FRAME_OK     status of last completed frame (1 = clean)
//   FRAME_LEN    byte count of last completed frame
//   FIRST_BYTE   first byte of last completed frame
//   FRAME_COUNT  completed frames since reset, wraps
//   ERR_COUNT    completed bad frames, saturates at 255
// ---------------------------------------------------------------------------
module gmii_rx_checker #(
    parameter int unsigned MAX_LEN = 64
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX_DV,
    input  logic       RX_ER,
    input  logic [7:0] RXD,
    output logic       BUSY,
    output logic       FRAME_DONE,
    output logic       FRAME_OK,
    output logic [7:0] FRAME_LEN,
    output logic [7:0] FIRST_BYTE,
    output logic [7:0] FRAME_COUNT,
    output logic [7:0] ERR_COUNT
);

    localparam int unsigned BYTE_W    = 8;
    localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);
    localparam logic [BYTE_W-1:0] CNT_MAX   = {BYTE_W{1'b1}};

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_RECV      = 2'd2,
        ST_DROP      = 2'd3
    } state_t;

    state_t              r_state;
    logic [BYTE_W-1:0]   r_expected;
    logic [BYTE_W-1:0]   r_len;
    logic [BYTE_W-1:0]   r_first;
    logic                r_err;
    logic                r_mismatch;
    logic                r_too_long;

    logic                r_busy;
    logic                r_frame_done;
    logic                r_frame_ok;
    logic [BYTE_W-1:0]   r_frame_len;
    logic [BYTE_W-1:0]   r_first_byte;
    logic [BYTE_W-1:0]   r_frame_count;
    logic [BYTE_W-1:0]   r_err_count;

    logic                w_frame_bad;

    // Any sticky condition makes the frame bad; the byte compare for the
    // current cycle is folded into r_mismatch on the same edge it happens.
    assign w_frame_bad = r_mismatch | r_err | r_too_long;

    // Frame delimiting FSM with registered status outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= ST_WAIT_IDLE;
            r_expected    <= '0;
            r_len         <= '0;
            r_first       <= '0;
            r_err         <= 1'b0;
            r_mismatch    <= 1'b0;
            r_too_long    <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_ok    <= 1'b0;
            r_frame_len   <= '0;
            r_first_byte  <= '0;
            r_frame_count <= '0;
            r_err_count   <= '0;
        end else begin
            r_frame_done <= 1'b0;

            case (r_state)
                // Swallow any frame already in progress when reset released
                ST_WAIT_IDLE: begin
                    if (!RX_DV) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (RX_DV) begin
                        r_first    <= RXD;
                        r_expected <= RXD + BYTE_W'(1);
                        r_len      <= BYTE_W'(1);
                        r_err      <= RX_ER;
                        r_mismatch <= 1'b0;
                        r_too_long <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_RECV;
                    end
                end

                ST_RECV: begin
                    if (RX_DV) begin
                        if (r_len < MAX_LEN_B) begin
                            if (RXD != r_expected) begin
                                r_mismatch <= 1'b1;
                            end
                            if (RX_ER) begin
                                r_err <= 1'b1;
                            end
                            r_expected <= r_expected + BYTE_W'(1);
                            r_len      <= r_len + BYTE_W'(1);
                        end else begin
                            // Byte beyond the limit is neither counted nor compared
                            r_too_long <= 1'b1;
                            r_state    <= ST_DROP;
                        end
                    end else begin
                        r_frame_done  <= 1'b1;
                        r_frame_ok    <= !w_frame_bad;
                        r_frame_len   <= r_len;
                        r_first_byte  <= r_first;
                        r_frame_count <= r_frame_count + BYTE_W'(1);
                        if (w_frame_bad && (r_err_count != CNT_MAX)) begin
                            r_err_count <= r_err_count + BYTE_W'(1);
                        end
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                ST_DROP: begin
                    if (!RX_DV) begin
                        r_frame_done  <= 1'b1;
                        r_frame_ok    <= !w_frame_bad;
                        r_frame_len   <= r_len;
                        r_first_byte  <= r_first;
                        r_frame_count <= r_frame_count + BYTE_W'(1);
                        if (w_frame_bad && (r_err_count != CNT_MAX)) begin
                            r_err_count <= r_err_count + BYTE_W'(1);
                        end
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_WAIT_IDLE;
                end
            endcase
        end
    end

    assign BUSY        = r_busy;
    assign FRAME_DONE  = r_frame_done;
    assign FRAME_OK    = r_frame_ok;
    assign FRAME_LEN   = r_frame_len;
    assign FIRST_BYTE  = r_first_byte;
    assign FRAME_COUNT = r_frame_count;
    assign ERR_COUNT   = r_err_count;

endmodule

// File: doc/gmii_rx_checker.md
# gmii_rx_checker

Receive-side GMII frame checker for the 1000BASE-X PCS bench. It sits on the GMII receive outputs of the PCS receiver (RX_DV, RX_ER, RXD) and mirrors the transmit-side stimulus. It delimits frames, verifies the payload is an incrementing byte sequence starting at the first received byte, and reports per-frame length, status and running counters in hardware. This allows end-to-end loopback to be judged without waveform inspection.

## Interface
Parameters:
- MAX_LEN, 64, maximum accepted frame length in bytes; legal range 2..255.

Ports:
- CLK  input  1  single clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- RX_DV  input  1  receive data valid from PCS receiver.
- RX_ER  input  1  receive error; only meaningful while RX_DV=1.
- RXD  input  8  receive data byte.
- BUSY  output  1  high while a frame is being received or dropped.
- FRAME_DONE  output  1  one-cycle pulse marking a completed frame.
- FRAME_OK  output  1  status of last completed frame; 1 = no error.
- FRAME_LEN  output  8  byte count of last completed frame.
- FIRST_BYTE  output  8  first byte of last completed frame.
- FRAME_COUNT  output  8  completed frames since reset; wraps mod 256.
- ERR_COUNT  output  8  completed frames with FRAME_OK=0; saturates at 255.

## Operation
- Reset (RESET sampled 1): all outputs 0; state WAIT_IDLE; internal flags, expected byte and length cleared. An in-flight frame is discarded and produces no FRAME_DONE.
- States: WAIT_IDLE, IDLE, RECV, DROP.
- WAIT_IDLE: go to IDLE on the first edge with RX_DV=0. This prevents a partial frame after reset from being accepted.
- IDLE: on RX_DV=1 do the following, then go to RECV:
  - capture RXD as first byte;
  - expected <= RXD+1 (mod 256);
  - len <= 1;
  - err flag <= RX_ER;
  - mismatch flag <= 0.
- RECV, RX_DV=1, len<MAX_LEN:
  - compare RXD with expected; if they differ, set the mismatch flag;
  - expected <= expected+1, wrapping 8'hFF to 8'h00;
  - len <= len+1;
  - RX_ER=1 sets the err flag.
- RECV, RX_DV=1, len==MAX_LEN: set the too_long flag and go to DROP. The byte is not counted or compared.
- DROP: ignore RXD and RX_ER while RX_DV=1; len holds at MAX_LEN.
- RECV or DROP, RX_DV=0: the frame ends. On the same edge:
  - FRAME_DONE <= 1;
  - FRAME_OK <= !(mismatch | err | too_long);
  - FRAME_LEN <= len;
  - FIRST_BYTE <= captured first byte;
  - FRAME_COUNT += 1;
  - ERR_COUNT += 1 if not OK, saturating at 255;
  - state <= IDLE.
- RX_ER with RX_DV=0 is ignored in every state (carrier extension / false carrier is out of scope).
- FRAME_OK, FRAME_LEN and FIRST_BYTE hold their values until the next frame end or reset.
- BUSY = (state==RECV) | (state==DROP).

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- FRAME_DONE is high for exactly one cycle: the cycle after the edge that samples RX_DV=0 following a frame.
- Frame end latency is 1 clock from RX_DV deassertion. Status outputs and counters update on the same edge as FRAME_DONE.
- Minimum inter-frame gap is 1 cycle of RX_DV=0. The edge that sees RX_DV=0 completes the frame and enters IDLE. A new frame starting on the next edge is accepted normally, so back-to-back frames with a 1-cycle gap are supported.
- A 1-byte frame (RX_DV high for one cycle) is legal: FRAME_LEN=1, FRAME_OK=!RX_ER.
- BUSY rises one cycle after the first RX_DV=1 and falls together with the FRAME_DONE rise.
- Reset has priority over every other event on the same edge, including a frame end.

## Test plan
- Nominal frame: after reset and one idle cycle, RX_DV=1 for 9 cycles with RXD 8'h1C..8'h24 -> one FRAME_DONE pulse with FRAME_OK=1, FRAME_LEN=9, FIRST_BYTE=8'h1C, FRAME_COUNT=1, ERR_COUNT=0.
- Payload error: RXD 8'h10,8'h11,8'h13,8'h14 -> FRAME_OK=0, FRAME_LEN=4, ERR_COUNT=1. Then frame 8'h20,8'h21 -> FRAME_OK=1, FRAME_COUNT=2, ERR_COUNT stays 1.
- RX_ER: 5-byte incrementing frame with RX_ER=1 on byte 3 -> FRAME_OK=0, FRAME_LEN=5. A separate RX_ER=1 pulse with RX_DV=0 -> no effect.
- Wrap and back-to-back: frame 8'hFE,8'hFF,8'h00,8'h01, a 1-cycle gap, then frame 8'h05,8'h06 -> two FRAME_DONE pulses, both OK, lengths 4 and 2, FRAME_COUNT=2.
- Overlong (MAX_LEN=64): 70-byte incrementing frame -> a single FRAME_DONE after RX_DV falls, FRAME_LEN=64, FRAME_OK=0, BUSY high throughout.
- Reset mid-frame: RESET=1 for one cycle on byte 3 while RX_DV stays high for 4 more bytes -> no FRAME_DONE, all counters 0. The next clean frame 8'h30..8'h33 reports OK, FRAME_LEN=4, FRAME_COUNT=1.
